alarm_zone_scanner: RTL
=======================

// Module: alarm_zone_scanner
// PURPOSE
//   Upstream sequencer for the 8:1 alarm mux. Drives select lines S2..S0 to step through
//   sensor zones 0..7, waits for the mux output to settle, then samples its ALARM return.
//   Debounces each zone; latches the first zone that trips and holds it until acknowledged.
// PARAMETERS
//   SETTLE_CYCLES   2   cycles S2..S0 are held stable before ALARM_IN is sampled (1..15)
//   DEBOUNCE_COUNT  3   consecutive high samples of one zone needed to trip (1..7)
// PORTS
//   CLK        in   1  system clock, rising edge
//   RST        in   1  asynchronous, active-high reset
//   ENABLE     in   1  1 = scan; 0 = go idle at the next zone boundary
//   ALARM_IN   in   1  ALARM output of the 8:1 mux for the current select
//   ACK        in   1  operator acknowledge; clears a latched trip
//   S2,S1,S0   out  1  registered zone select to the mux (S2 = MSB)
//   ALARM_OUT  out  1  latched trip indicator
//   ZONE       out  3  index of the tripped zone; valid while ALARM_OUT = 1
//   SCAN_DONE  out  1  one-cycle pulse when zone 7 has been sampled
//   BUSY       out  1  1 in any state other than IDLE
// BEHAVIOUR
//   Reset (async, RST = 1): state = IDLE; S = 3'b000; ALARM_OUT = 0; ZONE = 0; SCAN_DONE = 0;
//     BUSY = 0; all eight debounce counters = 0; settle counter = 0.
//   FSM states: IDLE, SETTLE, SAMPLE, TRIPPED.
//   IDLE:    with ENABLE = 1 -> SETTLE on the next edge, with S = 0.
//   SETTLE:  S is held constant for exactly SETTLE_CYCLES cycles, then -> SAMPLE.
//   SAMPLE:  one cycle. ALARM_IN is registered here.
//     ALARM_IN = 1: cnt[S]++ (saturates at DEBOUNCE_COUNT).
//     ALARM_IN = 0: cnt[S] = 0.
//     If cnt[S] + 1 = DEBOUNCE_COUNT: ALARM_OUT = 1, ZONE = S, -> TRIPPED. S is held.
//     Otherwise S advances by 1 mod 8 (7 wraps to 0). SCAN_DONE = 1 for this cycle when S was 7.
//       Next state is SETTLE if ENABLE = 1, otherwise IDLE.
//   TRIPPED: scanning stops; S, ZONE and ALARM_OUT are held.
//     ACK = 1: ALARM_OUT = 0, cnt[ZONE] = 0, S = ZONE + 1 mod 8, -> SETTLE (ENABLE = 1) or IDLE.
//   Timing:
//     Each zone takes SETTLE_CYCLES + 1 cycles, so a full sweep is 8 * (SETTLE_CYCLES + 1)
//       cycles (24 at the default).
//     ALARM_OUT rises on the edge that ends the SAMPLE cycle.
//   Precedence: ACK is ignored outside TRIPPED. ENABLE falling mid-SETTLE completes the zone
//     first. A trip has priority over the ENABLE = 0 return to IDLE. A mid-operation reset
//     aborts immediately to the reset values. Only one zone can be latched.
//   Widths: debounce counters are 3 bits; the settle counter is 4 bits.
// CONFIGURATION
//   ZONE_MASK_EN defined: adds input MASK [7:0].
//     A masked zone (MASK[z] = 1) is skipped: S jumps to the next unmasked zone in the same
//       cycle, cnt[z] is forced to 0, and the zone can never trip.
//     SCAN_DONE still pulses when the sweep passes zone 7.
//     If MASK = 8'hFF the block stays in IDLE and BUSY = 0.
//   ZONE_MASK_EN undefined: no MASK port; all 8 zones are always scanned.
// TESTING
//   1 Reset, ENABLE = 1, ALARM_IN = 0 -> S steps 0..7, 3 cycles per zone; SCAN_DONE pulses
//     every 24 cycles; ALARM_OUT stays 0.
//   2 ALARM_IN = 1 only while S = 5 -> ALARM_OUT = 1 and ZONE = 5 after the 3rd sweep;
//     S holds at 5.
//   3 Zone 2 high for 2 sweeps, low on the 3rd -> no trip; cnt[2] returns to 0.
//   4 In TRIPPED, pulse ACK -> ALARM_OUT = 0 next cycle; scan resumes at S = 6;
//     ACK while scanning has no effect.
//   5 Assert RST mid-SETTLE at S = 4 -> all outputs go to reset values immediately,
//     without waiting for a clock edge.
//   6 (ZONE_MASK_EN) MASK = 8'h20, zone 5 high -> S never equals 5 and there is no trip;
//     MASK = 8'hFF -> BUSY = 0.

Source files
------------

// File: rtl/alarm_zone_scanner.sv
// rtl/alarm_zone_scanner.sv - 8-zone alarm mux sequencer with per-zone debounce and trip latch
// Optional feature: define ZONE_MASK_EN to add the MASK[7:0] zone-skip input.
module alarm_zone_scanner #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int DEBOUNCE_COUNT = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic       ALARM_IN,
  input  logic       ACK,
`ifdef ZONE_MASK_EN
  input  logic [7:0] MASK,
`endif
  output logic       S2,
  output logic       S1,
  output logic       S0,
  output logic       ALARM_OUT,
  output logic [2:0] ZONE,
  output logic       SCAN_DONE,
  output logic       BUSY
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, TRIPPED} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] DEB_MAX     = 3'(DEBOUNCE_COUNT);
  localparam logic [3:0] DEB_TRIP    = 4'(DEBOUNCE_COUNT);

  state_t     state;
  logic [2:0] sel;
  logic [3:0] settle_cnt;
  logic [2:0] cnt [8];

  logic [2:0] next_sel;
  logic [2:0] first_sel;
  logic       all_masked;
  logic       zone_masked;
  logic       wrap;
  logic       trip;

`ifdef ZONE_MASK_EN
  // Nearest unmasked zone after sel (wrapping); downward scan so the closest wins.
  always_comb begin
    next_sel  = sel;
    first_sel = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      if (!MASK[3'(sel + 3'(i))]) next_sel = 3'(sel + 3'(i));
    end
    for (int i = 7; i >= 0; i--) begin
      if (!MASK[i]) first_sel = 3'(i);
    end
  end
  assign all_masked  = &MASK;
  assign zone_masked = MASK[sel];
`else
  assign next_sel    = sel + 3'd1;
  assign first_sel   = 3'd0;
  assign all_masked  = 1'b0;
  assign zone_masked = 1'b0;
`endif

  // A sweep completes whenever the advance does not move to a higher zone.
  assign wrap = (next_sel <= sel);
  assign trip = ALARM_IN && !zone_masked && (({1'b0, cnt[sel]} + 4'd1) == DEB_TRIP);

  assign {S2, S1, S0} = sel;
  assign BUSY         = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      sel        <= 3'd0;
      settle_cnt <= 4'd0;
      ALARM_OUT  <= 1'b0;
      ZONE       <= 3'd0;
      SCAN_DONE  <= 1'b0;
      for (int i = 0; i < 8; i++) cnt[i] <= 3'd0;
    end else begin
      SCAN_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (ENABLE && !all_masked) begin
            state      <= SETTLE;
            sel        <= first_sel;
            settle_cnt <= 4'd0;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= SAMPLE;
            settle_cnt <= 4'd0;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        SAMPLE: begin
          if (ALARM_IN) begin
            if (cnt[sel] != DEB_MAX) cnt[sel] <= cnt[sel] + 3'd1;
          end else begin
            cnt[sel] <= 3'd0;
          end
          if (trip) begin
            ALARM_OUT <= 1'b1;
            ZONE      <= sel;
            state     <= TRIPPED;
          end else begin
            sel       <= next_sel;
            SCAN_DONE <= wrap;
            state     <= (ENABLE && !all_masked) ? SETTLE : IDLE;
          end
        end
        TRIPPED: begin
          if (ACK) begin
            ALARM_OUT  <= 1'b0;
            cnt[ZONE]  <= 3'd0;
            sel        <= next_sel;
            settle_cnt <= 4'd0;
            state      <= (ENABLE && !all_masked) ? SETTLE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef ZONE_MASK_EN
      for (int i = 0; i < 8; i++) begin
        if (MASK[i]) cnt[i] <= 3'd0;
      end
`endif
    end
  end

endmodule
